// File: rtl/mem_arbiter_controller_if.sv
// Channel-request, response and external-memory signal bundle for mem_arbiter_controller.
// The slave modport is the controller's view; master is the channel/memory side.
interface mem_arbiter_controller_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_CH     = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]            ch_req_valid;
    logic [NUM_CH-1:0]            ch_req_we;
    logic [NUM_CH*ADDR_WIDTH-1:0] ch_req_addr;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_req_wdata;
    logic [NUM_CH-1:0]            ch_req_ready;
    logic [NUM_CH-1:0]            ch_rsp_valid;
    logic [DATA_WIDTH-1:0]        ch_rsp_rdata;
    logic                         ch_rsp_err;
    logic                         mem_read_valid;
    logic [ADDR_WIDTH-1:0]        mem_read_addr;
    logic                         mem_read_ready;
    logic [DATA_WIDTH-1:0]        mem_read_data;
    logic                         mem_write_valid;
    logic [ADDR_WIDTH-1:0]        mem_write_addr;
    logic [DATA_WIDTH-1:0]        mem_write_data;
    logic                         mem_write_ready;
    logic                         busy;
    logic [CH_W-1:0]              grant_id;

    modport slave (
        input  ch_req_valid, ch_req_we, ch_req_addr, ch_req_wdata,
        input  mem_read_ready, mem_read_data, mem_write_ready,
        output ch_req_ready, ch_rsp_valid, ch_rsp_rdata, ch_rsp_err,
        output mem_read_valid, mem_read_addr,
        output mem_write_valid, mem_write_addr, mem_write_data,
        output busy, grant_id
    );

    modport master (
        output ch_req_valid, ch_req_we, ch_req_addr, ch_req_wdata,
        output mem_read_ready, mem_read_data, mem_write_ready,
        input  ch_req_ready, ch_rsp_valid, ch_rsp_rdata, ch_rsp_err,
        input  mem_read_valid, mem_read_addr,
        input  mem_write_valid, mem_write_addr, mem_write_data,
        input  busy, grant_id
    );
endinterface

// File: rtl/mem_arbiter_controller.sv
// Round-robin arbiter of NUM_CH channels onto one memory port, one transaction in flight; 3-cycle min issue.
// Grant is a combinational ready in IDLE only; memory stalls hold the request. MEMCTRL_TIMEOUT_EN bounds the wait.
module mem_arbiter_controller #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_CH         = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic clk,
    input logic rst_n,
    mem_arbiter_controller_if.slave bus
);
    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, READ_REQ, WRITE_REQ, RESP} state_t;

    state_t                state;
    logic [CH_W-1:0]       rr_ptr;
    logic [CH_W-1:0]       grant_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  found;
    logic [CH_W-1:0]       gnt;
    int unsigned           idx;

    // First valid channel at or above rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && bus.ch_req_valid[idx]) begin
                found = 1'b1;
                gnt   = CH_W'(idx);
            end
        end
    end

    always_comb begin
        bus.ch_req_ready = '0;
        if (state == IDLE && found) bus.ch_req_ready[gnt] = 1'b1;
        bus.ch_rsp_valid = '0;
        if (state == RESP) bus.ch_rsp_valid[grant_q] = 1'b1;
    end

    assign bus.mem_read_valid  = (state == READ_REQ);
    assign bus.mem_read_addr   = (state == READ_REQ)  ? addr_q  : '0;
    assign bus.mem_write_valid = (state == WRITE_REQ);
    assign bus.mem_write_addr  = (state == WRITE_REQ) ? addr_q  : '0;
    assign bus.mem_write_data  = (state == WRITE_REQ) ? wdata_q : '0;
    assign bus.ch_rsp_rdata    = (state == RESP)      ? rdata_q : '0;
    assign bus.busy            = (state != IDLE);
    assign bus.grant_id        = grant_q;

`ifdef MEMCTRL_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_cnt;
    logic              err_q;
    logic              expired;
    // This cycle would be the TIMEOUT_CYCLES-th one without ready.
    assign expired        = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign bus.ch_rsp_err = (state == RESP) ? err_q : 1'b0;
`else
    assign bus.ch_rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEMCTRL_TIMEOUT_EN
            wait_cnt <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant_q <= gnt;
                    addr_q  <= bus.ch_req_addr[gnt*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_q <= bus.ch_req_wdata[gnt*DATA_WIDTH +: DATA_WIDTH];
                    state   <= bus.ch_req_we[gnt] ? WRITE_REQ : READ_REQ;
`ifdef MEMCTRL_TIMEOUT_EN
                    wait_cnt <= '0;
                    err_q    <= 1'b0;
`endif
                end
                READ_REQ: begin
                    if (bus.mem_read_ready) begin
                        rdata_q <= bus.mem_read_data;
                        state   <= RESP;
                    end
`ifdef MEMCTRL_TIMEOUT_EN
                    else if (expired) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= RESP;
                    end else wait_cnt <= wait_cnt + 1'b1;
`endif
                end
                WRITE_REQ: begin
                    if (bus.mem_write_ready) begin
                        rdata_q <= '0;
                        state   <= RESP;
                    end
`ifdef MEMCTRL_TIMEOUT_EN
                    else if (expired) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= RESP;
                    end else wait_cnt <= wait_cnt + 1'b1;
`endif
                end
                RESP: begin
                    rr_ptr <= (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
